uart_rx_ctrl: RTL and testbench

Controller that sits behind uart_rx_sampler_top on the 16x sample clock and sequences it. It performs the following:
- Synchronizes and edge-detects the sampler's data_valid and frame_err flags.
- Buffers received bytes in a small FIFO with a valid/ready output.
- Runs frame-error recovery by driving the sampler's Err_clr for a fixed window.
- Maintains sticky status: overflow flag and a saturating frame-error count.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_byte_fifo.sv | 41 ++++
 rtl/uart_rx_ctrl.sv | 98 +++++++++
 tb/tb_uart_rx_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive controller
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;
  typedef enum logic [1:0] {IDLE, RUN, ERR_CLR, ERR_WAIT} rx_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: byte FIFO with a registered head entry and wrap-bit pointers
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [UART_DATA_W-1:0]       din,
  output logic [UART_DATA_W-1:0]       dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [UART_DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, rd_next;
  logic do_push, do_pop;
  assign count   = wr_ptr - rd_ptr;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_next = rd_ptr + (AW+1)'(do_pop);
  // storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  // pointers and head register; the head bypasses din when the slot it lands on is written now
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_next;
      dout   <= (rd_next == wr_ptr) ? (do_push ? din : dout) : mem[rd_next[AW-1:0]];
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the UART sampler, buffers bytes and runs frame-error recovery
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int CLR_CYCLES  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk_sample,
  input  logic                         RST,
  input  logic                         enable,
  input  logic                         clr_status,
  input  logic [UART_DATA_W-1:0]       rx_data,
  input  logic                         rx_valid,
  input  logic                         rx_ferr,
  output logic                         Err_clr,
  output logic [UART_DATA_W-1:0]       m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt,
  output logic                         overflow,
  output logic [7:0]                   err_cnt,
  output logic                         busy_err
);
  localparam int CLW = $clog2(CLR_CYCLES);
  logic [SYNC_STAGES-1:0] v_sync, f_sync;
  logic v_prev, f_prev, v_rise, f_rise, push_req, pop, empty, full;
  rx_state_t st;
  logic [CLW-1:0] clr_cnt;
  assign v_rise   = v_sync[SYNC_STAGES-1] & ~v_prev;
  assign f_rise   = f_sync[SYNC_STAGES-1] & ~f_prev;
  assign push_req = (st == RUN) & v_rise & ~f_rise;
  assign pop      = m_ready & ~empty;
  assign m_valid  = ~empty;
  // synchronize sampler flags and keep a delayed copy for rise detection
  always_ff @(posedge clk_sample or posedge RST)
    if (RST) begin
      v_sync <= '0;
      f_sync <= '0;
      v_prev <= 1'b0;
      f_prev <= 1'b0;
    end else begin
      v_sync <= {v_sync[SYNC_STAGES-2:0], rx_valid};
      f_sync <= {f_sync[SYNC_STAGES-2:0], rx_ferr};
      v_prev <= v_sync[SYNC_STAGES-1];
      f_prev <= f_sync[SYNC_STAGES-1];
    end
  // recovery FSM with registered Err_clr and busy_err
  always_ff @(posedge clk_sample or posedge RST)
    if (RST) begin
      st       <= IDLE;
      clr_cnt  <= '0;
      Err_clr  <= 1'b0;
      busy_err <= 1'b0;
    end else begin
      case (st)
        IDLE: if (enable) st <= RUN;
        RUN:
          if (f_rise) begin
            st       <= ERR_CLR;
            clr_cnt  <= CLW'(CLR_CYCLES - 1);
            Err_clr  <= 1'b1;
            busy_err <= 1'b1;
          end else if (!enable) st <= IDLE;
        ERR_CLR:
          if (clr_cnt == '0) begin
            st      <= ERR_WAIT;
            Err_clr <= 1'b0;
          end else clr_cnt <= clr_cnt - 1'b1;
        default:
          if (!f_sync[SYNC_STAGES-1]) begin
            st       <= enable ? RUN : IDLE;
            busy_err <= 1'b0;
          end
      endcase
    end
  // sticky status; a clear request beats a same-cycle set or increment
  always_ff @(posedge clk_sample or posedge RST)
    if (RST) begin
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else begin
      overflow <= clr_status ? 1'b0 : (overflow | (push_req & full & ~pop));
      err_cnt  <= clr_status ? '0 :
                  ((st == RUN) && f_rise && err_cnt != ERR_CNT_MAX) ? err_cnt + 1'b1 : err_cnt;
    end
  uart_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_sample),
    .rst   (RST),
    .push  (push_req),
    .pop   (pop),
    .din   (rx_data),
    .dout  (m_data),
    .empty (empty),
    .full  (full),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  logic clk_sample = 1'b0;
  logic RST = 1'b1;
  logic enable = 1'b0, clr_status = 1'b0, rx_valid = 1'b0, rx_ferr = 1'b0, m_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic Err_clr, m_valid, overflow, busy_err;
  logic [7:0] m_data, err_cnt;
  logic [3:0] fifo_cnt;
  int n_cmp = 0;
  int n_err = 0;

  uart_rx_ctrl dut (
    .clk_sample (clk_sample),
    .RST        (RST),
    .enable     (enable),
    .clr_status (clr_status),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .Err_clr    (Err_clr),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_cnt   (fifo_cnt),
    .overflow   (overflow),
    .err_cnt    (err_cnt),
    .busy_err   (busy_err)
  );

  always #5 clk_sample = ~clk_sample;

  task automatic tick();
    @(posedge clk_sample);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    repeat (16) tick();
    rx_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_idle_err(input string tag);
    int w;
    w = 0;
    while (busy_err && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) chk(tag, 32'(busy_err), 32'd0);
  endtask

  initial begin
    int hi;
    repeat (2) tick();
    chk("rst_err_clr", 32'(Err_clr), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'h00);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_busy", 32'(busy_err), 32'd0);
    RST = 1'b0;
    enable = 1'b1;
    tick();

    // 1: single byte latency and pop
    rx_data = 8'hA5;
    rx_valid = 1'b1;
    repeat (2) tick();
    chk("t1_not_yet", 32'(m_valid), 32'd0);
    tick();
    chk("t1_m_valid", 32'(m_valid), 32'd1);
    chk("t1_m_data", 32'(m_data), 32'hA5);
    chk("t1_cnt", 32'(fifo_cnt), 32'd1);
    repeat (13) tick();
    rx_valid = 1'b0;
    repeat (3) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t1_pop_valid", 32'(m_valid), 32'd0);
    chk("t1_pop_cnt", 32'(fifo_cnt), 32'd0);

    // 2: overflow on the ninth byte, order preserved
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    chk("t2_cnt", 32'(fifo_cnt), 32'd8);
    chk("t2_overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t2_drain%0d", i), 32'(m_data), 32'(i));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    chk("t2_empty", 32'(m_valid), 32'd0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // 3: push and pop together while full
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    chk("t3_full", 32'(fifo_cnt), 32'd8);
    rx_data = 8'h18;
    rx_valid = 1'b1;
    repeat (2) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t3_cnt", 32'(fifo_cnt), 32'd8);
    chk("t3_overflow", 32'(overflow), 32'd0);
    chk("t3_head", 32'(m_data), 32'h11);
    repeat (13) tick();
    rx_valid = 1'b0;
    repeat (3) tick();
    m_ready = 1'b1;
    repeat (7) tick();
    chk("t3_last", 32'(m_data), 32'h18);
    tick();
    m_ready = 1'b0;
    chk("t3_drained", 32'(fifo_cnt), 32'd0);

    // 4: frame-error recovery
    rx_ferr = 1'b1;
    repeat (2) tick();
    chk("t4_pre_clr", 32'(Err_clr), 32'd0);
    tick();
    chk("t4_err_clr", 32'(Err_clr), 32'd1);
    chk("t4_busy", 32'(busy_err), 32'd1);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
    rx_data = 8'h77;
    rx_valid = 1'b1;
    hi = 0;
    while (Err_clr && hi < 100) begin
      hi++;
      tick();
    end
    chk("t4_clr_len", 32'(hi), 32'd32);
    chk("t4_wait_busy", 32'(busy_err), 32'd1);
    repeat (10) tick();
    chk("t4_hold_busy", 32'(busy_err), 32'd1);
    chk("t4_hold_clr", 32'(Err_clr), 32'd0);
    rx_ferr = 1'b0;
    repeat (2) tick();
    chk("t4_still_wait", 32'(busy_err), 32'd1);
    tick();
    chk("t4_back_run", 32'(busy_err), 32'd0);
    chk("t4_no_push", 32'(fifo_cnt), 32'd0);
    rx_valid = 1'b0;
    repeat (4) tick();
    send_byte(8'h3C);
    chk("t4_run_push", 32'(m_data), 32'h3C);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // 5: saturation and clear beating an increment
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rx_ferr = 1'b1;
      repeat (4) tick();
      rx_ferr = 1'b0;
      wait_idle_err("t5_timeout");
      repeat (3) tick();
    end
    chk("t5_sat", 32'(err_cnt), 32'd255);
    rx_ferr = 1'b1;
    repeat (2) tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t5_clr_wins", 32'(err_cnt), 32'd0);
    chk("t5_busy", 32'(busy_err), 32'd1);
    rx_ferr = 1'b0;
    wait_idle_err("t5_timeout2");
    repeat (3) tick();

    // 6: reset during recovery
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
    rx_ferr = 1'b1;
    repeat (3) tick();
    chk("t6_in_clr", 32'(Err_clr), 32'd1);
    chk("t6_cnt3", 32'(fifo_cnt), 32'd3);
    #2 RST = 1'b1;
    #1;
    chk("t6_async_clr", 32'(Err_clr), 32'd0);
    chk("t6_async_cnt", 32'(fifo_cnt), 32'd0);
    chk("t6_async_busy", 32'(busy_err), 32'd0);
    enable = 1'b0;
    rx_ferr = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    send_byte(8'hEE);
    send_byte(8'hEF);
    chk("t6_idle_cnt", 32'(fifo_cnt), 32'd0);
    chk("t6_idle_valid", 32'(m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
